// File: rtl/key_scan_multi.sv
// Multi-channel key conditioner: two-flop synchroniser, tick-sampled N-sample debounce
// and press / release / long-press / auto-repeat pulse generation per channel.
module key_scan_multi #(
    parameter int CLK_FREQ  = 100000000,
    parameter int KEY_NUM   = 4,
    parameter int SAMPLE_MS = 10,
    parameter int DEB_CNT   = 2,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [KEY_NUM-1:0] key_i,
    output logic [KEY_NUM-1:0] key_state_o,
    output logic [KEY_NUM-1:0] key_press_o,
    output logic [KEY_NUM-1:0] key_release_o,
    output logic [KEY_NUM-1:0] key_long_o,
    output logic [KEY_NUM-1:0] key_rep_o
);
    localparam int TICK_CYC   = CLK_FREQ / 1000 * SAMPLE_MS;
    localparam int LONG_TICKS = LONG_MS / SAMPLE_MS;
    localparam int REP_TICKS  = REPEAT_MS / SAMPLE_MS;
    localparam int TICK_W     = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam int DEB_W      = $clog2(DEB_CNT + 1);
    localparam int HOLD_W     = $clog2(LONG_TICKS + 1);
    localparam int REP_W      = (REP_TICKS > 1) ? $clog2(REP_TICKS) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYC - 1);
    localparam logic [DEB_W-1:0]  DEB_FULL  = DEB_W'(DEB_CNT);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_TICKS);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'((REP_TICKS > 0) ? REP_TICKS - 1 : 0);

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

    logic [TICK_W-1:0]  tick_cnt;
    logic               tick;
    logic [KEY_NUM-1:0] sync_a;
    logic [KEY_NUM-1:0] sync_b;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // Synchronisers idle at 1 so a reset looks like "all keys released".
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sync_a <= '1;
            sync_b <= '1;
        end else begin
            sync_a <= key_i;
            sync_b <= sync_a;
        end
    end

    for (genvar k = 0; k < KEY_NUM; k++) begin : g_ch
        state_t            state, state_nx;
        logic [DEB_W-1:0]  deb_cnt, deb_nx, deb_inc;
        logic [HOLD_W-1:0] hold_cnt, hold_nx;
        logic [REP_W-1:0]  rep_cnt, rep_nx;
        logic              long_done, long_done_nx;
        logic              level, level_nx;
        logic              prs, prs_nx, rls, rls_nx, lng, lng_nx, rpt, rpt_nx;
        logic              released;
        logic              s;

        assign s       = sync_b[k];
        assign deb_inc = deb_cnt + DEB_W'(1);

        always_comb begin
            state_nx     = state;
            deb_nx       = deb_cnt;
            hold_nx      = hold_cnt;
            rep_nx       = rep_cnt;
            long_done_nx = long_done;
            level_nx     = level;
            prs_nx       = 1'b0;
            rls_nx       = 1'b0;
            lng_nx       = 1'b0;
            rpt_nx       = 1'b0;
            released     = 1'b0;
            if (tick) begin
                unique case (state)
                    IDLE: begin
                        if (!s) begin
                            if (DEB_CNT == 1) begin
                                state_nx     = HELD;
                                level_nx     = 1'b1;
                                prs_nx       = 1'b1;
                                hold_nx      = '0;
                                long_done_nx = 1'b0;
                                deb_nx       = '0;
                            end else begin
                                state_nx = PRESS_CHK;
                                deb_nx   = DEB_W'(1);
                            end
                        end
                    end
                    PRESS_CHK: begin
                        if (s) begin
                            state_nx = IDLE;
                            deb_nx   = '0;
                        end else if (deb_inc == DEB_FULL) begin
                            state_nx     = HELD;
                            level_nx     = 1'b1;
                            prs_nx       = 1'b1;
                            hold_nx      = '0;
                            long_done_nx = 1'b0;
                            deb_nx       = '0;
                        end else begin
                            deb_nx = deb_inc;
                        end
                    end
                    HELD: begin
                        if (s) begin
                            if (DEB_CNT == 1) begin
                                state_nx = IDLE;
                                level_nx = 1'b0;
                                rls_nx   = 1'b1;
                                released = 1'b1;
                                deb_nx   = '0;
                            end else begin
                                state_nx = REL_CHK;
                                deb_nx   = DEB_W'(1);
                            end
                        end
                    end
                    REL_CHK: begin
                        if (!s) begin
                            state_nx = HELD;
                            deb_nx   = '0;
                        end else if (deb_inc == DEB_FULL) begin
                            state_nx = IDLE;
                            level_nx = 1'b0;
                            rls_nx   = 1'b1;
                            released = 1'b1;
                            deb_nx   = '0;
                        end else begin
                            deb_nx = deb_inc;
                        end
                    end
                endcase

                // A release on this tick suppresses any long or repeat event.
                if ((state == HELD || state == REL_CHK) && !released) begin
                    if (hold_cnt != HOLD_MAX) begin
                        hold_nx = hold_cnt + HOLD_W'(1);
                    end
                    if (!long_done && hold_nx == HOLD_MAX) begin
                        lng_nx       = 1'b1;
                        long_done_nx = 1'b1;
                        rep_nx       = '0;
                    end else if (long_done && REP_TICKS > 0) begin
                        if (rep_cnt == REP_LAST) begin
                            rpt_nx = 1'b1;
                            rep_nx = '0;
                        end else begin
                            rep_nx = rep_cnt + REP_W'(1);
                        end
                    end
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rstn_i) begin
                state     <= IDLE;
                deb_cnt   <= '0;
                hold_cnt  <= '0;
                rep_cnt   <= '0;
                long_done <= 1'b0;
                level     <= 1'b0;
                prs       <= 1'b0;
                rls       <= 1'b0;
                lng       <= 1'b0;
                rpt       <= 1'b0;
            end else begin
                state     <= state_nx;
                deb_cnt   <= deb_nx;
                hold_cnt  <= hold_nx;
                rep_cnt   <= rep_nx;
                long_done <= long_done_nx;
                level     <= level_nx;
                prs       <= prs_nx;
                rls       <= rls_nx;
                lng       <= lng_nx;
                rpt       <= rpt_nx;
            end
        end

        assign key_state_o[k]   = level;
        assign key_press_o[k]   = prs;
        assign key_release_o[k] = rls;
        assign key_long_o[k]    = lng;
        assign key_rep_o[k]     = rpt;
    end
endmodule

// File: tb/tb_key_scan_multi.sv
// Bench for key_scan_multi: tick-level behavioural model checked every cycle on two
// instances (repeat enabled / disabled), plus directed scenarios with literal expectations.
module tb_key_scan_multi;
    localparam int TICK_CYC = 10;
    localparam int DEB      = 2;
    localparam int LONG_T   = 10;
    localparam int REP_A    = 5;
    localparam int REP_B    = 0;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] key, key_nr;
    logic [3:0] st_a, pr_a, rl_a, lg_a, rp_a;
    logic [3:0] st_b, pr_b, rl_b, lg_b, rp_b;

    always #5 clk = ~clk;

    key_scan_multi #(
        .CLK_FREQ(1000), .KEY_NUM(4), .SAMPLE_MS(10), .DEB_CNT(2), .LONG_MS(100), .REPEAT_MS(50)
    ) dut (
        .clk_i(clk), .rstn_i(rstn), .key_i(key),
        .key_state_o(st_a), .key_press_o(pr_a), .key_release_o(rl_a),
        .key_long_o(lg_a), .key_rep_o(rp_a)
    );

    key_scan_multi #(
        .CLK_FREQ(1000), .KEY_NUM(4), .SAMPLE_MS(10), .DEB_CNT(2), .LONG_MS(100), .REPEAT_MS(0)
    ) dut_nr (
        .clk_i(clk), .rstn_i(rstn), .key_i(key_nr),
        .key_state_o(st_b), .key_press_o(pr_b), .key_release_o(rl_b),
        .key_long_o(lg_b), .key_rep_o(rp_b)
    );

    // Model: per channel, count consecutive samples disagreeing with the debounced level,
    // and count ticks since the press tick to place long and repeat events.
    int         m_phase;
    logic [3:0] m_d1 [2];
    logic [3:0] m_d2 [2];
    logic [3:0] m_lvl [2];
    logic [3:0] m_prs [2];
    logic [3:0] m_rls [2];
    logic [3:0] m_lng [2];
    logic [3:0] m_rpt [2];
    int         m_run [2][4];
    int         m_since [2][4];

    always @(posedge clk) begin : model
        int         ph, rt;
        bit         tk;
        int         rn [2][4];
        int         sn [2][4];
        logic [3:0] lvl [2], prs [2], rls [2], lng [2], rpt [2], d1 [2], d2 [2];
        logic [3:0] s;
        logic       p;
        ph = m_phase; rn = m_run; sn = m_since; lvl = m_lvl; d1 = m_d1; d2 = m_d2;
        for (int d = 0; d < 2; d++) begin
            prs[d] = '0; rls[d] = '0; lng[d] = '0; rpt[d] = '0;
        end
        if (!rstn) begin
            ph = 0;
            for (int d = 0; d < 2; d++) begin
                d1[d] = '1; d2[d] = '1; lvl[d] = '0;
                for (int k = 0; k < 4; k++) begin
                    rn[d][k] = 0; sn[d][k] = 0;
                end
            end
        end else begin
            tk = (ph == TICK_CYC - 1);
            ph = tk ? 0 : ph + 1;
            for (int d = 0; d < 2; d++) begin
                rt    = (d == 0) ? REP_A : REP_B;
                s     = d2[d];
                d2[d] = d1[d];
                d1[d] = (d == 0) ? key : key_nr;
                if (tk) begin
                    for (int k = 0; k < 4; k++) begin
                        p = ~s[k];
                        if (p != lvl[d][k]) rn[d][k] = rn[d][k] + 1;
                        else rn[d][k] = 0;
                        if (rn[d][k] == DEB) begin
                            rn[d][k] = 0;
                            lvl[d][k] = p;
                            if (p) begin
                                prs[d][k] = 1'b1;
                                sn[d][k] = 0;
                            end else begin
                                rls[d][k] = 1'b1;
                            end
                        end else if (lvl[d][k]) begin
                            sn[d][k] = sn[d][k] + 1;
                            if (sn[d][k] == LONG_T) lng[d][k] = 1'b1;
                            else if (rt > 0 && sn[d][k] > LONG_T && (sn[d][k] - LONG_T) % rt == 0)
                                rpt[d][k] = 1'b1;
                        end
                    end
                end
            end
        end
        m_phase <= ph; m_run <= rn; m_since <= sn; m_lvl <= lvl; m_d1 <= d1; m_d2 <= d2;
        m_prs <= prs; m_rls <= rls; m_lng <= lng; m_rpt <= rpt;
    end

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         press_n [4], rel_n [4], long_n [4], rep_n [4];
    int         press_at [4], rel_at [4], long_at [4];
    int         rep2_at [16];
    int         pvec_n = 0;
    logic [3:0] pvec_last = '0;
    logic [3:0] rvec_last = '0;
    int         b_press_n = 0, b_rel_n = 0, b_long_n = 0, b_rep_n = 0;
    int         t0, r0, bp, br, bl, brp, bpv;

    task automatic cmp(input string nm, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // Advance n cycles; each cycle compare both instances with the model and log events.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            cmp("model_rep", {st_a, pr_a, rl_a, lg_a, rp_a},
                {m_lvl[0], m_prs[0], m_rls[0], m_lng[0], m_rpt[0]});
            cmp("model_norep", {st_b, pr_b, rl_b, lg_b, rp_b},
                {m_lvl[1], m_prs[1], m_rls[1], m_lng[1], m_rpt[1]});
            for (int k = 0; k < 4; k++) begin
                if (pr_a[k]) begin press_n[k]++; press_at[k] = cyc; end
                if (rl_a[k]) begin rel_n[k]++;   rel_at[k]   = cyc; end
                if (lg_a[k]) begin long_n[k]++;  long_at[k]  = cyc; end
                if (rp_a[k]) begin
                    if (k == 2) rep2_at[rep_n[k] & 15] = cyc;
                    rep_n[k]++;
                end
            end
            if (pr_a != 4'b0) begin pvec_n++; pvec_last = pr_a; end
            if (rl_a != 4'b0) rvec_last = rl_a;
            if (pr_b[2]) b_press_n++;
            if (rl_b[2]) b_rel_n++;
            if (lg_b[2]) b_long_n++;
            if (rp_b[2]) b_rep_n++;
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            press_n[k] = 0; rel_n[k] = 0; long_n[k] = 0; rep_n[k] = 0;
            press_at[k] = 0; rel_at[k] = 0; long_at[k] = 0;
        end
        rstn = 1'b0; key = '1; key_nr = '1;
        step(1);
        chk("reset_outputs", int'({st_a, pr_a, rl_a, lg_a, rp_a}), 0);
        step(2);
        rstn = 1'b1;
        step(20);

        // Clean press / release on channel 0
        bp = press_n[0]; br = rel_n[0]; bl = long_n[0];
        key[0] = 1'b0; t0 = cyc;
        step(30);
        chk("clean_state_high", int'(st_a[0]), 1);
        step(30);
        key[0] = 1'b1;
        step(40);
        chk("clean_press_count", press_n[0] - bp, 1);
        chk_rng("clean_press_latency", press_at[0] - t0, 13, 23);
        chk("clean_release_count", rel_n[0] - br, 1);
        chk("clean_hold_cycles", rel_at[0] - press_at[0], 60);
        chk("clean_no_long", long_n[0] - bl, 0);
        chk("clean_state_low", int'(st_a[0]), 0);

        // Bounce on channel 1
        bp = press_n[1]; br = rel_n[1]; bl = long_n[1];
        for (int i = 0; i < 15; i++) begin
            key[1] = (i % 2 == 1);
            step(7);
        end
        key[1] = 1'b1;
        step(40);
        chk("bounce_at_most_one_press", int'((press_n[1] - bp) <= 1), 1);
        chk("bounce_paired_release", rel_n[1] - br, press_n[1] - bp);
        chk("bounce_no_long", long_n[1] - bl, 0);
        chk("bounce_state_low", int'(st_a[1]), 0);

        // Long press and repeat on channel 2; release lands on a would-be repeat tick
        bp = press_n[2]; br = rel_n[2]; bl = long_n[2]; brp = rep_n[2];
        key[2] = 1'b0;
        step(250);
        key[2] = 1'b1;
        step(40);
        chk("long_count", long_n[2] - bl, 1);
        chk("long_delay", long_at[2] - press_at[2], 100);
        chk("rep_count", rep_n[2] - brp, 2);
        chk("rep1_delay", rep2_at[brp & 15] - press_at[2], 150);
        chk("rep2_delay", rep2_at[(brp + 1) & 15] - press_at[2], 200);
        chk("long_release_count", rel_n[2] - br, 1);
        chk("long_release_delay", rel_at[2] - press_at[2], 250);

        // Simultaneous channels 0 and 3
        bpv = pvec_n;
        key[3] = 1'b0; key[0] = 1'b0;
        step(40);
        chk("simul_press_events", pvec_n - bpv, 1);
        chk("simul_press_vec", int'(pvec_last), 9);
        key[3] = 1'b1;
        step(40);
        chk("simul_release_vec", int'(rvec_last), 8);
        chk("simul_state_after", int'(st_a), 1);
        key[0] = 1'b1;
        step(40);

        // Reset in the middle of a hold on channel 2
        key[2] = 1'b0;
        step(60);
        rstn = 1'b0;
        step(1);
        chk("midreset_outputs", int'({st_a, pr_a, rl_a, lg_a, rp_a}), 0);
        step(2);
        rstn = 1'b1; r0 = cyc;
        bp = press_n[2]; bl = long_n[2];
        step(140);
        chk("midreset_new_press", press_n[2] - bp, 1);
        chk_rng("midreset_press_latency", press_at[2] - r0, 13, 23);
        chk("midreset_long_count", long_n[2] - bl, 1);
        chk("midreset_long_delay", long_at[2] - press_at[2], 100);
        key[2] = 1'b1;
        step(40);

        // Repeat disabled instance, 300-cycle hold
        bp = b_press_n; br = b_rel_n; bl = b_long_n; brp = b_rep_n;
        key_nr[2] = 1'b0;
        step(300);
        key_nr[2] = 1'b1;
        step(40);
        chk("norep_press", b_press_n - bp, 1);
        chk("norep_long", b_long_n - bl, 1);
        chk("norep_rep", b_rep_n - brp, 0);
        chk("norep_release", b_rel_n - br, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
